// File: rtl/cam_frame_capture_ctrl.sv
// ---------------------------------------------------------------------------
// cam_frame_capture_ctrl
//
// Captures assembled camera pixels into a single-port frame BRAM. Capture is
// armed by `start`, then aligns to the next vsync rising edge (frame
// boundary). It writes pixels to linear addresses starting at 0, counts
// pixels and lines, and reports each finished frame with a one-cycle
// frame_ready pulse. The block runs entirely in the camera pixel clock domain.
//
// Ports
//   p_clock      camera pixel clock (only clock)
//   rst          asynchronous, active-high reset
//   start        one-cycle arm request, honoured only while idle
//   continuous   re-capture every frame; sampled at each frame end
//   abort        return to idle on the next cycle from any state
//   vsync        camera vsync; rising edge marks a frame boundary
//   href         camera href; falling edge marks the end of a line
//   pixel_valid  assembled pixel strobe
//   pixel_data   assembled RGB444 pixel
//   bram_we      BRAM write enable (one cycle after an accepted pixel)
//   bram_addr    BRAM write address
//   bram_din     BRAM write data
//   busy         high while armed or capturing
//   frame_ready  one-cycle pulse at frame end
//   frame_ok     valid with frame_ready: exact pixel and line geometry
//   pix_count    pixels received in last frame, including dropped ones
//   line_count   href falling edges seen in last frame
//   overflow     sticky: a pixel was dropped; cleared on start
// ---------------------------------------------------------------------------
module cam_frame_capture_ctrl #(
  parameter int unsigned H_ACTIVE = 320,
  parameter int unsigned V_ACTIVE = 240,
  parameter int unsigned ADDR_W   = 17,
  parameter int unsigned PIX_W    = 12
) (
  input  logic              p_clock,
  input  logic              rst,
  input  logic              start,
  input  logic              continuous,
  input  logic              abort,
  input  logic              vsync,
  input  logic              href,
  input  logic              pixel_valid,
  input  logic [PIX_W-1:0]  pixel_data,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [PIX_W-1:0]  bram_din,
  output logic              busy,
  output logic              frame_ready,
  output logic              frame_ok,
  output logic [ADDR_W:0]   pix_count,
  output logic [9:0]        line_count,
  output logic              overflow
);

  // Frame size needs one bit more than the BRAM address, because the
  // frame may fill the whole address space exactly.
  localparam logic [ADDR_W:0] FRAME_PIX   = (ADDR_W+1)'(H_ACTIVE * V_ACTIVE);
  localparam logic [9:0]      FRAME_LINES = 10'(V_ACTIVE);
  localparam logic [ADDR_W:0] PIX_MAX     = '1;
  localparam logic [9:0]      LINE_MAX    = '1;
  localparam logic [ADDR_W:0] ADDR_ONE    = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_CAPTURE
  } state_t;

  state_t            state;
  logic              vsync_d;
  logic              href_d;
  logic [ADDR_W:0]   wr_addr;
  logic [ADDR_W:0]   pix_cnt;
  logic [9:0]        line_cnt;

  logic              vs_rise;
  logic              href_fall;
  logic              frame_full;

  assign vs_rise    = vsync & ~vsync_d;
  assign href_fall  = ~href & href_d;
  assign frame_full = (wr_addr >= FRAME_PIX);

  always_ff @(posedge p_clock or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      vsync_d     <= 1'b0;
      href_d      <= 1'b0;
      wr_addr     <= '0;
      pix_cnt     <= '0;
      line_cnt    <= '0;
      bram_we     <= 1'b0;
      bram_addr   <= '0;
      bram_din    <= '0;
      busy        <= 1'b0;
      frame_ready <= 1'b0;
      frame_ok    <= 1'b0;
      pix_count   <= '0;
      line_count  <= '0;
      overflow    <= 1'b0;
    end else begin
      vsync_d     <= vsync;
      href_d      <= href;
      bram_we     <= 1'b0;
      frame_ready <= 1'b0;
      frame_ok    <= 1'b0;

      if (abort) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state    <= S_ARM;
              busy     <= 1'b1;
              overflow <= 1'b0;
            end
          end

          S_ARM: begin
            if (vs_rise) begin
              state    <= S_CAPTURE;
              wr_addr  <= '0;
              pix_cnt  <= '0;
              line_cnt <= '0;
            end
          end

          S_CAPTURE: begin
            if (vs_rise) begin
              // Frame boundary: report the finished frame. A pixel or href
              // edge landing on this same cycle belongs to neither frame;
              // the pixel is dropped and flagged.
              frame_ready <= 1'b1;
              pix_count   <= pix_cnt;
              line_count  <= line_cnt;
              frame_ok    <= (pix_cnt == FRAME_PIX) && (line_cnt == FRAME_LINES);
              if (pixel_valid) begin
                overflow <= 1'b1;
              end
              wr_addr  <= '0;
              pix_cnt  <= '0;
              line_cnt <= '0;
              if (!continuous) begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end
            end else begin
              if (pixel_valid) begin
                if (!frame_full) begin
                  bram_we   <= 1'b1;
                  bram_addr <= wr_addr[ADDR_W-1:0];
                  bram_din  <= pixel_data;
                  wr_addr   <= wr_addr + ADDR_ONE;
                end else begin
                  overflow <= 1'b1;
                end
                if (pix_cnt != PIX_MAX) begin
                  pix_cnt <= pix_cnt + ADDR_ONE;
                end
              end
              if (href_fall && (line_cnt != LINE_MAX)) begin
                line_cnt <= line_cnt + 10'd1;
              end
            end
          end

          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cam_frame_capture_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cam_frame_capture_ctrl
//
// Drives a small 4x2 frame geometry with directed and randomized frame
// sequences. A reference model that works at the frame level (pixel and line
// tallies, expected write stream) predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_cam_frame_capture_ctrl;

  localparam int unsigned H  = 4;
  localparam int unsigned V  = 2;
  localparam int unsigned AW = 4;
  localparam int unsigned PW = 12;
  localparam int TOTAL    = H * V;
  localparam int PIX_SAT  = (1 << (AW + 1)) - 1;
  localparam int LINE_SAT = 1023;

  logic          p_clock = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          continuous = 1'b0;
  logic          abort = 1'b0;
  logic          vsync = 1'b0;
  logic          href = 1'b0;
  logic          pixel_valid = 1'b0;
  logic [PW-1:0] pixel_data = '0;
  logic          bram_we;
  logic [AW-1:0] bram_addr;
  logic [PW-1:0] bram_din;
  logic          busy;
  logic          frame_ready;
  logic          frame_ok;
  logic [AW:0]   pix_count;
  logic [9:0]    line_count;
  logic          overflow;

  cam_frame_capture_ctrl #(
    .H_ACTIVE(H),
    .V_ACTIVE(V),
    .ADDR_W  (AW),
    .PIX_W   (PW)
  ) dut (
    .p_clock    (p_clock),
    .rst        (rst),
    .start      (start),
    .continuous (continuous),
    .abort      (abort),
    .vsync      (vsync),
    .href       (href),
    .pixel_valid(pixel_valid),
    .pixel_data (pixel_data),
    .bram_we    (bram_we),
    .bram_addr  (bram_addr),
    .bram_din   (bram_din),
    .busy       (busy),
    .frame_ready(frame_ready),
    .frame_ok   (frame_ok),
    .pix_count  (pix_count),
    .line_count (line_count),
    .overflow   (overflow)
  );

  always #5 p_clock = ~p_clock;

  int    n_checks = 0;
  int    n_fail   = 0;
  string phase    = "init";

  // Frame-level model: 0 idle, 1 waiting for frame boundary, 2 capturing.
  int m_mode;
  int m_pix;
  int m_lines;
  int m_acc;
  bit prev_vs;
  bit prev_hr;

  // Expected outputs after the next active clock edge.
  bit e_we, e_ready, e_ok, e_busy, e_ovf;
  int e_addr, e_din, e_pc, e_lc;

  bit use_seq = 1'b0;
  int seq_val = 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL [%s] %s: got 0x%0h, expected 0x%0h at %0t", phase, tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_val("bram_we",     32'(bram_we),     32'(e_we));
    check_val("bram_addr",   32'(bram_addr),   32'(e_addr));
    check_val("bram_din",    32'(bram_din),    32'(e_din));
    check_val("busy",        32'(busy),        32'(e_busy));
    check_val("frame_ready", 32'(frame_ready), 32'(e_ready));
    check_val("frame_ok",    32'(frame_ok),    32'(e_ok));
    check_val("pix_count",   32'(pix_count),   32'(e_pc));
    check_val("line_count",  32'(line_count),  32'(e_lc));
    check_val("overflow",    32'(overflow),    32'(e_ovf));
  endtask

  task automatic model_clear();
    m_mode = 0; m_pix = 0; m_lines = 0; m_acc = 0;
    prev_vs = 0; prev_hr = 0;
    e_we = 0; e_ready = 0; e_ok = 0; e_busy = 0; e_ovf = 0;
    e_addr = 0; e_din = 0; e_pc = 0; e_lc = 0;
  endtask

  function automatic logic [PW-1:0] next_pix();
    logic [PW-1:0] v;
    if (use_seq) begin
      v = PW'(seq_val);
      seq_val++;
    end else begin
      v = PW'($urandom_range(0, (1 << PW) - 1));
    end
    return v;
  endfunction

  // One clock cycle: check what the previous edge produced, then drive new
  // inputs and predict the outcome of the coming edge.
  task automatic tick(input bit st, input bit cont, input bit ab, input bit vs,
                      input bit hr, input bit pv, input logic [PW-1:0] pd);
    bit vs_rise, hf;
    @(negedge p_clock);
    check_outputs();
    vs_rise = vs && !prev_vs;
    hf      = !hr && prev_hr;
    prev_vs = vs;
    prev_hr = hr;
    e_we = 0; e_ready = 0; e_ok = 0;
    if (ab) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      if (st) begin
        m_mode = 1;
        e_ovf  = 0;
      end
    end else if (m_mode == 1) begin
      if (vs_rise) begin
        m_mode = 2; m_pix = 0; m_lines = 0; m_acc = 0;
      end
    end else begin
      if (vs_rise) begin
        e_ready = 1;
        e_pc    = m_pix;
        e_lc    = m_lines;
        e_ok    = (m_pix == TOTAL) && (m_lines == V);
        if (pv) e_ovf = 1;
        m_pix = 0; m_lines = 0; m_acc = 0;
        if (!cont) m_mode = 0;
      end else begin
        if (pv) begin
          if (m_acc < TOTAL) begin
            e_we   = 1;
            e_addr = m_acc;
            e_din  = int'(pd);
            m_acc++;
          end else begin
            e_ovf = 1;
          end
          if (m_pix < PIX_SAT) m_pix++;
        end
        if (hf && m_lines < LINE_SAT) m_lines++;
      end
    end
    e_busy = (m_mode != 0);
    start = st; continuous = cont; abort = ab; vsync = vs; href = hr;
    pixel_valid = pv; pixel_data = pd;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 0; continuous = 0; abort = 0; vsync = 0; href = 0;
    pixel_valid = 0; pixel_data = '0;
    #1;
    model_clear();
    check_outputs();
    @(negedge p_clock);
    check_outputs();
    rst = 1'b0;
  endtask

  task automatic idle(input int n, input bit cont);
    for (int i = 0; i < n; i++) tick(0, cont, 0, 0, 0, 0, '0);
  endtask

  task automatic vs_pulse(input bit cont, input bit pix_on_rise);
    tick(0, cont, 0, 1, 0, pix_on_rise, next_pix());
    tick(0, cont, 0, 1, 0, 0, '0);
    tick(0, cont, 0, 0, 0, 0, '0);
  endtask

  task automatic send_line(input int npix, input bit cont, input bit gaps);
    for (int i = 0; i < npix; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) tick(0, cont, 0, 0, 1, 0, '0);
      tick(0, cont, 0, 0, 1, 1, next_pix());
    end
    tick(0, cont, 0, 0, 0, 0, '0);
  endtask

  task automatic send_frame(input int nlines, input int npix, input bit cont, input bit gaps);
    for (int l = 0; l < nlines; l++) send_line(npix, cont, gaps);
  endtask

  initial begin
    #1;
    phase = "reset";
    do_reset();
    idle(2, 0);

    phase = "basic_frame";
    use_seq = 1; seq_val = 1;
    tick(1, 0, 0, 0, 0, 0, '0);
    vs_pulse(0, 0);
    send_frame(2, 4, 0, 0);
    vs_pulse(0, 0);
    use_seq = 0;
    idle(3, 0);

    phase = "arm_ignores_pixels";
    tick(1, 0, 0, 0, 0, 0, '0);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 1, 1, next_pix());
    tick(0, 0, 0, 0, 0, 0, '0);
    vs_pulse(0, 0);
    send_frame(2, 4, 0, 1);
    vs_pulse(0, 0);
    idle(2, 0);

    phase = "overflow_9px";
    tick(1, 0, 0, 0, 0, 0, '0);
    vs_pulse(0, 0);
    send_line(4, 0, 0);
    send_line(5, 0, 0);
    vs_pulse(0, 0);
    idle(2, 0);

    phase = "short_frame";
    tick(1, 0, 0, 0, 0, 0, '0);
    vs_pulse(0, 0);
    send_line(4, 0, 0);
    vs_pulse(0, 0);
    idle(2, 0);

    phase = "continuous";
    tick(1, 1, 0, 0, 0, 0, '0);
    vs_pulse(1, 0);
    for (int f = 0; f < 2; f++) begin
      send_frame(2, 4, 1, 1);
      vs_pulse(1, 0);
    end
    send_frame(2, 4, 0, 1);
    vs_pulse(0, 0);
    idle(3, 0);

    phase = "pixel_on_boundary";
    tick(1, 0, 0, 0, 0, 0, '0);
    vs_pulse(0, 0);
    send_frame(2, 4, 0, 0);
    vs_pulse(0, 1);
    idle(2, 0);

    phase = "pix_count_saturate";
    tick(1, 0, 0, 0, 0, 0, '0);
    vs_pulse(0, 0);
    send_line(PIX_SAT + 4, 0, 0);
    vs_pulse(0, 0);
    idle(2, 0);

    phase = "abort_mid_line";
    tick(1, 0, 0, 0, 0, 0, '0);
    vs_pulse(0, 0);
    send_line(4, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 1, 1, next_pix());
    tick(0, 0, 1, 0, 1, 1, next_pix());
    idle(3, 0);
    tick(1, 0, 0, 0, 0, 0, '0);
    vs_pulse(0, 0);
    send_frame(2, 4, 0, 0);
    vs_pulse(0, 0);
    idle(2, 0);

    phase = "reset_mid_frame";
    tick(1, 0, 0, 0, 0, 0, '0);
    vs_pulse(0, 0);
    tick(0, 0, 0, 0, 1, 1, next_pix());
    tick(0, 0, 0, 0, 1, 1, next_pix());
    @(posedge p_clock);
    #1;
    check_outputs();
    do_reset();
    idle(2, 0);
    vs_pulse(0, 0);
    tick(1, 0, 0, 0, 0, 0, '0);
    vs_pulse(0, 0);
    send_frame(2, 4, 0, 0);
    vs_pulse(0, 0);
    idle(2, 0);

    phase = "random";
    for (int r = 0; r < 40; r++) begin
      bit c;
      c = 1'($urandom_range(0, 1));
      if (m_mode == 0) begin
        tick(1, c, 0, 0, 0, 0, '0);
        if ($urandom_range(0, 2) == 0) send_line(2, c, 0);
        vs_pulse(c, 0);
      end
      if ($urandom_range(0, 4) == 0) tick(1, c, 0, 0, 0, 0, '0);
      send_frame($urandom_range(0, 3), $urandom_range(0, 6), c, 1);
      if ($urandom_range(0, 7) == 0) begin
        tick(0, c, 1, 0, 0, $urandom_range(0, 1), next_pix());
        idle(2, c);
      end else begin
        vs_pulse(c, 1'($urandom_range(0, 3) == 0));
      end
      idle($urandom_range(0, 2), c);
    end
    idle(4, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
